// File: rtl/fu_div_pkg.sv
// Shared definitions for the fu_div iterative divider: op codes, FSM states, timing limits.
package fu_div_pkg;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ITER = 3'd1,
    FIX  = 3'd2,
    WAIT = 3'd3,
    DONE = 3'd4
  } div_state_e;

  localparam int DIV_ITER_EDGES  = 16;
  localparam int DIV_MIN_LATENCY = 18;
  localparam int DIV_MAX_LATENCY = 31;

  function automatic logic [31:0] abs32(input logic [31:0] v, input logic neg);
    return neg ? 32'(-v) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring shift-subtract step. quo_i holds the remaining dividend bits
// in its upper part; each step shifts one out of the MSB and shifts the quotient bit into the LSB.
module div_step (
  input  logic [32:0] rem_i,
  input  logic [31:0] quo_i,
  input  logic [31:0] den_i,
  output logic [32:0] rem_o,
  output logic [31:0] quo_o
);

  logic [33:0] shifted;
  logic [32:0] diff;
  logic        ge;

  always_comb begin
    shifted = {rem_i, quo_i[31]};
    ge      = (shifted >= {2'b00, den_i});
    // Only used when ge, where the true difference is below den and fits in 33 bits.
    diff    = shifted[32:0] - {1'b0, den_i};
    rem_o   = ge ? diff : shifted[32:0];
    quo_o   = {quo_i[30:0], ge};
  end

endmodule

// File: rtl/fu_div.sv
// Fixed-latency RV32M divider (DIV/DIVU/REM/REMU), two restoring steps per clock.
// Optional divide-by-zero flag output enabled by defining FU_DIV_DZ_FLAG_EN.
module fu_div
  import fu_div_pkg::*;
#(
  parameter int LATENCY = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EN,
  input  logic [1:0]  op,
  input  logic [31:0] num,
  input  logic [31:0] den,
  output logic [31:0] res,
  output logic        finish,
  output logic        busy,
`ifdef FU_DIV_DZ_FLAG_EN
  output logic        dz,
`endif
  output div_state_e  dbg_state_o
);

  if (LATENCY < DIV_MIN_LATENCY || LATENCY > DIV_MAX_LATENCY) begin : g_bad_latency
    $error("fu_div: LATENCY must be within 18..31");
  end

  // Handshake: EN is a single-cycle issue pulse sampled only in IDLE or DONE (ignored
  // otherwise, no backpressure); finish is a one-cycle strobe marking res (and dz) valid.
  div_state_e  state_q;
  logic [4:0]  cnt_q;
  logic        sel_rem_q;
  logic        sn_q;
  logic        sd_q;
  logic [31:0] den_q;
  logic [32:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] res_q;
  logic        finish_q;
  logic        busy_q;
`ifdef FU_DIV_DZ_FLAG_EN
  logic        dz_q;
`endif

  logic [32:0] rem_mid, rem_d;
  logic [31:0] quo_mid, quo_d;
  logic        den_zero;
  logic [31:0] q_fix, r_fix;

  div_step u_step0 (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .den_i (den_q),
    .rem_o (rem_mid),
    .quo_o (quo_mid)
  );

  div_step u_step1 (
    .rem_i (rem_mid),
    .quo_i (quo_mid),
    .den_i (den_q),
    .rem_o (rem_d),
    .quo_o (quo_d)
  );

  // Divide-by-zero keeps the all-ones quotient unsigned; remainder sign fixup yields raw num.
  always_comb begin
    den_zero = (den_q == 32'd0);
    q_fix    = den_zero ? 32'hFFFF_FFFF : abs32(quo_q, sn_q ^ sd_q);
    r_fix    = abs32(rem_q[31:0], sn_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sel_rem_q <= 1'b0;
      sn_q      <= 1'b0;
      sd_q      <= 1'b0;
      den_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      res_q     <= '0;
      finish_q  <= 1'b0;
      busy_q    <= 1'b0;
`ifdef FU_DIV_DZ_FLAG_EN
      dz_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          finish_q <= 1'b0;
          if (EN) begin
            sel_rem_q <= op[1];
            sn_q      <= ~op[0] & num[31];
            sd_q      <= ~op[0] & den[31];
            quo_q     <= abs32(num, ~op[0] & num[31]);
            den_q     <= abs32(den, ~op[0] & den[31]);
            rem_q     <= '0;
            cnt_q     <= 5'd1;
            busy_q    <= 1'b1;
`ifdef FU_DIV_DZ_FLAG_EN
            dz_q      <= 1'b0;
`endif
            state_q   <= ITER;
          end
        end
        ITER: begin
          cnt_q <= cnt_q + 5'd1;
          rem_q <= rem_d;
          quo_q <= quo_d;
          if (cnt_q == 5'(DIV_ITER_EDGES)) state_q <= FIX;
        end
        FIX: begin
          cnt_q   <= cnt_q + 5'd1;
          res_q   <= sel_rem_q ? r_fix : q_fix;
`ifdef FU_DIV_DZ_FLAG_EN
          dz_q    <= den_zero;
`endif
          state_q <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'(LATENCY)) begin
            finish_q <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign res         = res_q;
  assign finish      = finish_q;
  assign busy        = busy_q;
  assign dbg_state_o = state_q;
`ifdef FU_DIV_DZ_FLAG_EN
  assign dz          = dz_q;
`endif

endmodule

// File: tb/tb_fu_div.sv
// Self-checking bench for fu_div: directed vector table, multi-cycle corner sequences,
// and randomized operations checked against a plain-arithmetic reference model.
module tb_fu_div;

  localparam int LAT = 24;

  logic        clk = 1'b0;
  logic        rst;
  logic        EN;
  logic [1:0]  op;
  logic [31:0] num;
  logic [31:0] den;
  logic [31:0] res;
  logic        finish;
  logic        busy;
`ifdef FU_DIV_DZ_FLAG_EN
  logic        dz;
`endif
  fu_div_pkg::div_state_e dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  fu_div #(.LATENCY(LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .EN          (EN),
    .op          (op),
    .num         (num),
    .den         (den),
    .res         (res),
    .finish      (finish),
    .busy        (busy),
`ifdef FU_DIV_DZ_FLAG_EN
    .dz          (dz),
`endif
    .dbg_state_o (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model: RV32M semantics from plain 64-bit arithmetic
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb;
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return o[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return o[1] ? (a % b) : (a / b);
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // driver: call just after a negedge; the following posedge is E0
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    EN  = 1'b1;
    op  = o;
    num = a;
    den = b;
    @(posedge clk);
    #1;
    EN  = 1'b0;
    num = $urandom;
    den = $urandom;
  endtask

  // samples at the negedge after E_k for k = k0 .. end; finish must be high only at k == LAT
  task automatic wait_result(input int k0, input logic [31:0] exp, input logic exp_dz,
                             input string name, input bit stop);
    int fin_bad  = 0;
    int busy_bad = 0;
    int k_end    = stop ? LAT : LAT + 2;
    for (int k = k0; k <= k_end; k++) begin
      @(negedge clk);
      if (finish !== 1'(k == LAT)) fin_bad++;
      if (busy !== 1'(k < LAT)) busy_bad++;
      if (k == LAT) begin
        chk({name, "_res"}, res, exp);
`ifdef FU_DIV_DZ_FLAG_EN
        chk({name, "_dz"}, 32'(dz), 32'(exp_dz));
`else
        if (exp_dz) n_checks = n_checks + 0;
`endif
      end
    end
    chk({name, "_finish_timing"}, fin_bad, 0);
    chk({name, "_busy_timing"}, busy_bad, 0);
  endtask

  initial begin
    logic [31:0] first_res;
    int          fin_cnt;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    vecs.push_back('{2'b00, 32'd100,        32'd7,          32'd14,         "div_100_7"});
    vecs.push_back('{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  "rem_m7_2"});
    vecs.push_back('{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  "div_m7_2"});
    vecs.push_back('{2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  "divu_max_1"});
    vecs.push_back('{2'b11, 32'hFFFF_FFFF,  32'h10,         32'hF,          "remu_max_16"});
    vecs.push_back('{2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF,  "div_5_0"});
    vecs.push_back('{2'b10, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  "rem_m5_0"});
    vecs.push_back('{2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF,  "divu_5_0"});
    vecs.push_back('{2'b11, 32'd7,          32'd0,          32'd7,          "remu_7_0"});
    vecs.push_back('{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  "div_ovf"});
    vecs.push_back('{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          "rem_ovf"});
    vecs.push_back('{2'b00, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  "div_m100_7"});
    vecs.push_back('{2'b10, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  "rem_m100_7"});
    vecs.push_back('{2'b00, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  "div_100_m7"});
    vecs.push_back('{2'b10, 32'd100,        32'hFFFF_FFF9,  32'd2,          "rem_100_m7"});
    vecs.push_back('{2'b01, 32'h8000_0000,  32'd3,          32'h2AAA_AAAA,  "divu_big_3"});
    vecs.push_back('{2'b11, 32'h8000_0000,  32'd3,          32'd2,          "remu_big_3"});

    // reset
    rst = 1'b1;
    EN  = 1'b0;
    op  = 2'b00;
    num = '0;
    den = '0;
    repeat (3) @(negedge clk);
    chk("rst_res", res, 32'd0);
    chk("rst_finish", 32'(finish), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(fu_div_pkg::IDLE));
`ifdef FU_DIV_DZ_FLAG_EN
    chk("rst_dz", 32'(dz), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // directed vector table
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_result(0, vecs[i].exp, vecs[i].b == 32'd0, vecs[i].name, 1'b0);
    end

    // issue in the same cycle finish is high
    issue(2'b00, 32'd1000, 32'd10);
    wait_result(0, 32'd100, 1'b0, "b2b_first", 1'b1);
    issue(2'b11, 32'd1000, 32'd7);
    @(negedge clk);
    chk("b2b_finish_drop", 32'(finish), 32'd0);
    chk("b2b_res_held", res, 32'd100);
    chk("b2b_busy", 32'(busy), 32'd1);
    wait_result(1, 32'd6, 1'b0, "b2b_second", 1'b0);

    // EN while busy must be ignored
    issue(2'b00, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    issue(2'b10, 32'd55, 32'd3);
    wait_result(5, 32'd14, 1'b0, "busy_ignore", 1'b0);

    // reset mid-operation
    issue(2'b01, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_res", res, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    fin_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (finish) fin_cnt++;
    end
    chk("midrst_no_finish", fin_cnt, 0);
    chk("midrst_res_after", res, 32'd0);
    chk("midrst_state", 32'(dbg_state), 32'(fu_div_pkg::IDLE));

    // randomized operations against the reference model
    for (int n = 0; n < 200; n++) begin
      ro = 2'($urandom_range(0, 3));
      ra = pick();
      rb = pick();
      issue(ro, ra, rb);
      first_res = model(ro, ra, rb);
      wait_result(0, first_res, rb == 32'd0, $sformatf("rand%0d_op%0d", n, ro), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
